ps2_key_event_rx: RTL and testbench

Parametrised PS/2 keyboard receiver. It synchronises and debounces `ps2_clk`/`ps2_data`, deframes 11-bit device-to-host frames and checks start, parity and stop bits. It folds the `E0`/`F0` prefix bytes into flags on a single key event, then buffers those events in a FIFO with a ready/valid output. It sits between the board PS/2 pins and the scancode-to-ASCII/keymap logic, replacing the single-byte, unbuffered receiver.

---
 rtl/ps2_key_event_rx.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronise, debounce, deframe, fold E0/F0 prefixes, buffer key events.
// Optional prefix folding is enabled by defining PS2_PREFIX_DECODE_EN; otherwise every byte is raw.
module ps2_key_event_rx #(
  parameter int unsigned DEBOUNCE_CYCLES = 500,
  parameter int unsigned TIMEOUT_CYCLES  = 5000,
  parameter int unsigned FIFO_AW         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FifoFull = {1'b1, {FIFO_AW{1'b0}}};

  // Synchronisers reset to the idle-high line level.
  logic clk_meta_q, sclk_q, dat_meta_q, sdat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      sclk_q     <= 1'b1;
      dat_meta_q <= 1'b1;
      sdat_q     <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      sclk_q     <= clk_meta_q;
      dat_meta_q <= ps2_data;
      sdat_q     <= dat_meta_q;
    end
  end

  // Counter saturates at DEBOUNCE_CYCLES so each low phase yields a single sample.
  logic [DebW-1:0] deb_q;
  logic            sample;

  assign sample = !sclk_q && (deb_q == DebW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || sclk_q) begin
      deb_q <= '0;
    end else if (deb_q != DebW'(DEBOUNCE_CYCLES)) begin
      deb_q <= deb_q + DebW'(1);
    end
  end

  logic [3:0]      bit_q;
  logic [9:0]      shift_q;
  logic [TmoW-1:0] tmo_q;
  logic            byte_vld_q;
  logic [7:0]      byte_q;
  logic            err_pend_q;
  logic            frame_err_q;
  logic            timeout;
  logic            frame_good;

  assign timeout    = sclk_q && (bit_q != 4'd0) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
  // shift_q holds start in [0], data in [8:1], parity in [9]; sdat_q is the stop bit.
  assign frame_good = !shift_q[0] && (^shift_q[9:1]) && sdat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_q       <= 4'd0;
      shift_q     <= '0;
      tmo_q       <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= 8'h00;
      err_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      err_pend_q  <= 1'b0;
      frame_err_q <= err_pend_q;
      if (!sclk_q || (bit_q == 4'd0) || timeout) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TmoW'(1);
      end
      if (timeout) begin
        bit_q      <= 4'd0;
        err_pend_q <= 1'b1;
      end else if (sample) begin
        if (bit_q == 4'd10) begin
          bit_q <= 4'd0;
          if (frame_good) begin
            byte_vld_q <= 1'b1;
            byte_q     <= shift_q[8:1];
          end else begin
            err_pend_q <= 1'b1;
          end
        end else begin
          shift_q <= {sdat_q, shift_q[9:1]};
          bit_q   <= bit_q + 4'd1;
        end
      end
    end
  end

  assign frame_err = frame_err_q;

  logic       push;
  logic [9:0] push_data;

`ifdef PS2_PREFIX_DECODE_EN
  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e state_q, state_d;
  logic   flag_brk, flag_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    flag_brk = 1'b0;
    flag_ext = 1'b0;
    unique case (state_q)
      StExt:    flag_ext = 1'b1;
      StBrk:    flag_brk = 1'b1;
      StExtBrk: begin
        flag_ext = 1'b1;
        flag_brk = 1'b1;
      end
      default:  ;
    endcase
    push_data = {flag_brk, flag_ext, byte_q};
    if (err_pend_q) begin
      state_d = StIdle;
    end else if (byte_vld_q) begin
      if (byte_q == 8'hE0) begin
        state_d = flag_brk ? StExtBrk : StExt;
      end else if (byte_q == 8'hF0) begin
        state_d = flag_ext ? StExtBrk : StBrk;
      end else begin
        push    = 1'b1;
        state_d = StIdle;
      end
    end
  end
`else
  always_comb begin
    push      = byte_vld_q;
    push_data = {2'b00, byte_q};
  end
`endif

  logic [9:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               overflow_q;
  logic               pop, full, do_push;

  assign pop     = (cnt_q != '0) && ev_ready;
  assign full    = (cnt_q == FifoFull);
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + FIFO_AW'(1);
      end
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + (FIFO_AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (FIFO_AW + 1)'(1);
        default: ;
      endcase
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign ev_valid = (cnt_q != '0);
  assign {ev_break, ev_ext, ev_code} = mem_q[rd_q];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Randomised and directed bench for ps2_key_event_rx against a queue-based event model.
module tb_ps2_key_event_rx;

  localparam int unsigned Deb   = 4;
  localparam int unsigned Tmo   = 200;
  localparam int unsigned Aw    = 2;
  localparam int          Depth = 4;
  localparam int          LowT  = 12;
  localparam int          HighT = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_break, ev_ext, frame_err, overflow;
  logic [7:0] ev_code;

  always #5 clk = ~clk;

  ps2_key_event_rx #(
    .DEBOUNCE_CYCLES(Deb),
    .TIMEOUT_CYCLES (Tmo),
    .FIFO_AW        (Aw)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_break (ev_break),
    .ev_ext   (ev_ext),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected events, accepted count, prefix flags, overflow, error count.
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int         accepted = 0;
  bit         m_brk = 0, m_ext = 0, m_ovf = 0;
  int         m_err = 0;
  int         err_seen = 0;
  int         err_run = 0;

  always @(negedge clk) begin
    if (reset) begin
      err_run = 0;
    end else begin
      if (ev_valid && ev_ready) got_q.push_back({ev_break, ev_ext, ev_code});
      if (frame_err) begin
        err_run++;
      end else if (err_run > 0) begin
        err_seen++;
        check("err_width", err_run, 1);
        err_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_event(input logic [9:0] ev);
    if (accepted - got_q.size() >= Depth) begin
      m_ovf = 1;
    end else begin
      exp_q.push_back(ev);
      accepted++;
    end
  endtask

  task automatic model_error();
    m_err++;
    m_brk = 0;
    m_ext = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad_par);
    if (bad_par) begin
      model_error();
    end else begin
`ifdef PS2_PREFIX_DECODE_EN
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        push_event({m_brk, m_ext, b});
        m_brk = 0;
        m_ext = 0;
      end
`else
      push_event({2'b00, b});
`endif
    end
  endtask

  // pulse raises ev_ready for exactly the cycle in which the stop-bit byte is written.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit pulse);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (3) tick();
      ps2_clk = 1'b0;
      for (int c = 1; c <= LowT; c++) begin
        tick();
        if (pulse && i == 10 && c == Deb + 2) ev_ready = 1'b1;
        if (pulse && i == 10 && c == Deb + 3) ev_ready = 1'b0;
      end
      ps2_clk = 1'b1;
      repeat (HighT) tick();
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    send_frame(b, bad_par, 11, 1'b0);
    model_byte(b, bad_par);
  endtask

  task automatic checkpoint(input string tag);
    int n;
    ev_ready = 1'b1;
    repeat (40) tick();
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_event"}, got_q[i], exp_q[i]);
    check({tag, "_valid"}, ev_valid, 0);
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_errs"}, err_seen, m_err);
    got_q.delete();
    exp_q.delete();
    accepted = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    accepted = 0;
    m_brk = 0;
    m_ext = 0;
    m_ovf = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] codes [5];
    codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24; codes[3] = 8'h2D; codes[4] = 8'h2C;

    do_reset();
    check("rst_valid", ev_valid, 0);
    check("rst_code", ev_code, 0);
    check("rst_break", ev_break, 0);
    check("rst_ext", ev_ext, 0);
    check("rst_err", frame_err, 0);
    check("rst_ovf", overflow, 0);

    ev_ready = 1'b1;
    send_byte(8'h1C, 0);
    checkpoint("make");

    ev_ready = 1'b1;
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h75, 0);
    checkpoint("prefix");

    send_byte(8'h1C, 1);
    checkpoint("badpar");

    send_byte(8'hF0, 0);
    send_byte(8'h33, 1);
    send_byte(8'h1C, 0);
    checkpoint("bad_clears");

    send_frame(8'h1C, 0, 5, 0);
    repeat (Tmo + 30) tick();
    model_error();
    send_byte(8'h1C, 0);
    checkpoint("timeout");

    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(codes[i], 0);
    check("ovf_flag", overflow, 1);
    check("ovf_valid", ev_valid, 1);
    checkpoint("overflow");

    do_reset();
    check("ovf_cleared", overflow, 0);
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(codes[i], 0);
    send_frame(codes[4], 0, 11, 1'b1);
    model_byte(codes[4], 0);
    check("simul_ovf", overflow, m_ovf);
    checkpoint("simul");

    ev_ready = 1'b1;
    send_byte(8'hF0, 0);
    send_frame(8'h5A, 0, 6, 0);
    do_reset();
    check("midrst_valid", ev_valid, 0);
    check("midrst_err", frame_err, 0);
    send_byte(8'h1C, 0);
    checkpoint("midreset");

    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      int         r;
      ev_ready = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 7);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      send_byte(b, ($urandom_range(0, 7) == 0));
    end
    checkpoint("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
